time_of_day_counter: RTL and testbench

Free-running wall-clock counter that produces the 5-bit hour of day (0–23), plus minutes and seconds, for the traffic-light controller. Its `hoursOut` feeds the day/night classifier directly; the minute and second fields go to the display and sequencing logic. It divides the system clock down to one-second steps internally, supports a synchronous time-set load, and flags hour and midnight rollovers with single-cycle strobes.

---
 rtl/time_of_day_counter.sv | 110 +++++++++++
 tb/tb_time_of_day_counter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/time_of_day_counter.sv
// Wall-clock counter: prescales the system clock to one-second steps and keeps
// hours/minutes/seconds with time-set load and hour/midnight rollover strobes.
module time_of_day_counter #(
  parameter int unsigned PRESCALE   = 50000000,
  parameter int unsigned RESET_HOUR = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       runEn,
  input  logic       setEn,
  input  logic [4:0] setHours,
  input  logic [5:0] setMinutes,
  output logic [4:0] hoursOut,
  output logic [5:0] minutesOut,
  output logic [5:0] secondsOut,
  output logic       hourStrobe,
  output logic       midnightStrobe,
  output logic       setError
);

  localparam int unsigned PreW = $clog2(PRESCALE);
  localparam logic [PreW-1:0] PreMax = PreW'(PRESCALE - 1);

  // Run/hold mode follows runEn each cycle rather than being stored.
  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } modeT;

  modeT            mode;
  logic [PreW-1:0] pre;
  logic [PreW-1:0] preNext;
  logic [4:0]      hoursNext;
  logic [5:0]      minutesNext;
  logic [5:0]      secondsNext;
  logic            hourStrobeNext;
  logic            midnightStrobeNext;
  logic            setErrorNext;
  logic            secTick;
  logic            setValid;

  always_comb begin
    mode               = runEn ? RUN : HOLD;
    secTick            = (mode == RUN) && (pre == PreMax);
    setValid           = (setHours <= 5'd23) && (setMinutes <= 6'd59);
    preNext            = pre;
    hoursNext          = hoursOut;
    minutesNext        = minutesOut;
    secondsNext        = secondsOut;
    hourStrobeNext     = 1'b0;
    midnightStrobeNext = 1'b0;
    setErrorNext       = 1'b0;

    // A set request pre-empts any tick on the same cycle.
    if (setEn) begin
      if (setValid) begin
        hoursNext   = setHours;
        minutesNext = setMinutes;
        secondsNext = 6'd0;
        preNext     = '0;
      end else begin
        setErrorNext = 1'b1;
      end
    end else if (mode == RUN) begin
      if (secTick) begin
        preNext = '0;
        if (secondsOut == 6'd59) begin
          secondsNext = 6'd0;
          if (minutesOut == 6'd59) begin
            minutesNext    = 6'd0;
            hourStrobeNext = 1'b1;
            if (hoursOut == 5'd23) begin
              hoursNext          = 5'd0;
              midnightStrobeNext = 1'b1;
            end else begin
              hoursNext = hoursOut + 5'd1;
            end
          end else begin
            minutesNext = minutesOut + 6'd1;
          end
        end else begin
          secondsNext = secondsOut + 6'd1;
        end
      end else begin
        preNext = pre + PreW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre            <= '0;
      hoursOut       <= 5'(RESET_HOUR);
      minutesOut     <= 6'd0;
      secondsOut     <= 6'd0;
      hourStrobe     <= 1'b0;
      midnightStrobe <= 1'b0;
      setError       <= 1'b0;
    end else begin
      pre            <= preNext;
      hoursOut       <= hoursNext;
      minutesOut     <= minutesNext;
      secondsOut     <= secondsNext;
      hourStrobe     <= hourStrobeNext;
      midnightStrobe <= midnightStrobeNext;
      setError       <= setErrorNext;
    end
  end

endmodule

// File: tb/tb_time_of_day_counter.sv
// Directed bench for time_of_day_counter with PRESCALE=4 (four cycles per second).
module tb_time_of_day_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       runEn;
  logic       setEn;
  logic [4:0] setHours;
  logic [5:0] setMinutes;
  logic [4:0] hoursOut;
  logic [5:0] minutesOut;
  logic [5:0] secondsOut;
  logic       hourStrobe;
  logic       midnightStrobe;
  logic       setError;

  int passCount  = 0;
  int checkCount = 0;
  int hourHits;
  int midHits;
  int holdBad;

  time_of_day_counter #(.PRESCALE(4), .RESET_HOUR(6)) dut (
    .clk(clk), .rst_n(rst_n), .runEn(runEn), .setEn(setEn),
    .setHours(setHours), .setMinutes(setMinutes),
    .hoursOut(hoursOut), .minutesOut(minutesOut), .secondsOut(secondsOut),
    .hourStrobe(hourStrobe), .midnightStrobe(midnightStrobe), .setError(setError)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
  endtask

  task automatic checkTime(input string tag, input int h, input int m, input int s);
    checkVal({tag, ".h"}, 32'(hoursOut), 32'(h));
    checkVal({tag, ".m"}, 32'(minutesOut), 32'(m));
    checkVal({tag, ".s"}, 32'(secondsOut), 32'(s));
  endtask

  // Advance n rising edges, leaving the bench 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic setTime(input int h, input int m);
    setEn      = 1'b1;
    setHours   = 5'(h);
    setMinutes = 6'(m);
    step(1);
    setEn = 1'b0;
  endtask

  // Run one simulated minute, counting strobe pulses; checks the hour just before the rollover edge.
  task automatic runMinute(input string tag, input int hourBefore);
    hourHits = 0;
    midHits  = 0;
    for (int i = 1; i <= 240; i++) begin
      step(1);
      if (hourStrobe) hourHits++;
      if (midnightStrobe) midHits++;
      if (i == 239) checkVal({tag, ".hourBefore"}, 32'(hoursOut), 32'(hourBefore));
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    runEn      = 1'b1;
    setEn      = 1'b0;
    setHours   = 5'd0;
    setMinutes = 6'd0;

    // Reset state and first tick at edge 4
    #12;
    checkTime("reset", 6, 0, 0);
    checkVal("reset.hourStrobe", 32'(hourStrobe), 0);
    checkVal("reset.midStrobe", 32'(midnightStrobe), 0);
    checkVal("reset.setError", 32'(setError), 0);
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step(1);
      checkVal("firstTick.hold", 32'(secondsOut), 0);
    end
    step(1);
    checkTime("firstTick", 6, 0, 1);

    // Hour rollover 06:59 -> 07:00
    setTime(6, 59);
    checkTime("set0659", 6, 59, 0);
    runMinute("hourRoll", 6);
    checkTime("hourRoll", 7, 0, 0);
    checkVal("hourRoll.strobeNow", 32'(hourStrobe), 1);
    step(1);
    checkVal("hourRoll.strobeLow", 32'(hourStrobe), 0);
    checkVal("hourRoll.strobeCount", 32'(hourHits), 1);
    checkVal("hourRoll.midCount", 32'(midHits), 0);

    // Midnight wrap 23:59 -> 00:00
    setTime(23, 59);
    runMinute("midnight", 23);
    checkTime("midnight", 0, 0, 0);
    checkVal("midnight.hourNow", 32'(hourStrobe), 1);
    checkVal("midnight.midNow", 32'(midnightStrobe), 1);
    step(1);
    checkVal("midnight.midLow", 32'(midnightStrobe), 0);
    checkVal("midnight.hourCount", 32'(hourHits), 1);
    checkVal("midnight.midCount", 32'(midHits), 1);

    // Invalid set at 12:34:02 with pre=0
    setTime(12, 34);
    step(8);
    checkTime("pre.invalid", 12, 34, 2);
    setEn = 1'b1; setHours = 5'd24; setMinutes = 6'd10;
    step(1);
    setEn = 1'b0;
    checkTime("badHour", 12, 34, 2);
    checkVal("badHour.setError", 32'(setError), 1);
    checkVal("badHour.strobe", 32'(hourStrobe), 0);
    step(1);
    checkVal("badHour.errLow", 32'(setError), 0);
    setEn = 1'b1; setHours = 5'd5; setMinutes = 6'd60;
    step(1);
    setEn = 1'b0;
    checkTime("badMin", 12, 34, 2);
    checkVal("badMin.setError", 32'(setError), 1);
    checkVal("badMin.midStrobe", 32'(midnightStrobe), 0);
    // pre was 1 and held through the rejected set: tick lands 3 edges later
    step(2);
    checkVal("badMin.preHeld", 32'(secondsOut), 2);
    step(1);
    checkVal("badMin.tick", 32'(secondsOut), 3);

    // Set collides with the tick that would roll 08:59:59
    setTime(8, 59);
    step(236);
    checkTime("collide.pre", 8, 59, 59);
    step(3);
    setEn = 1'b1; setHours = 5'd19; setMinutes = 6'd59;
    step(1);
    setEn = 1'b0;
    checkTime("collide", 19, 59, 0);
    checkVal("collide.strobe", 32'(hourStrobe), 0);
    checkVal("collide.setError", 32'(setError), 0);

    // Hold with pre=2, resume needs 2 edges
    step(2);
    runEn   = 1'b0;
    holdBad = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (secondsOut != 6'd0) holdBad++;
    end
    checkVal("hold.changes", 32'(holdBad), 0);
    runEn = 1'b1;
    step(1);
    checkVal("resume.1", 32'(secondsOut), 0);
    step(1);
    checkVal("resume.2", 32'(secondsOut), 1);

    // Async reset between edges at 15:20:07
    setTime(15, 20);
    step(28);
    checkTime("preReset", 15, 20, 7);
    #2;
    rst_n = 1'b0;
    #1;
    checkTime("asyncReset", 6, 0, 0);
    checkVal("asyncReset.hourStrobe", 32'(hourStrobe), 0);
    checkVal("asyncReset.midStrobe", 32'(midnightStrobe), 0);
    #4;
    rst_n = 1'b1;
    step(3);
    checkVal("afterReset.hold", 32'(secondsOut), 0);
    step(1);
    checkVal("afterReset.tick", 32'(secondsOut), 1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
